// File: rtl/hlsm_core_arbiter.sv
// ---------------------------------------------------------------------------
// hlsm_core_arbiter
//
// Round-robin arbiter and sequencer that shares one HLSM compute core among
// NREQ requesters. It picks a requester, latches that requester's three
// operands into registers that feed the core, pulses CoreStart, waits for
// CoreDone, then returns the core result with a one-cycle Ack. A watchdog
// aborts a job whose core never finishes, returns an error response and
// pulses CoreRst.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   DW       operand/result width
//   TIMEOUT  number of WAIT cycles allowed before the job is aborted (>= 4)
//
// Ports:
//   Clk, Rst            clock; synchronous active-high reset
//   Req[NREQ]           request level per requester, held until Ack
//   ReqA/ReqB/ReqC      flattened operands, requester i owns [i*DW +: DW]
//   Ack[NREQ]           one-hot, one-cycle completion pulse
//   RespData, RespErr   result and timeout flag, valid while Ack is high
//   CoreStart, CoreRst  one-cycle start / abort pulses to the core
//   CoreA/CoreB/CoreC   registered operands to the core
//   CoreDone, CoreX     core completion and result
//   Busy                high in every state except IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module hlsm_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*DW-1:0] ReqA,
    input  logic [NREQ*DW-1:0] ReqB,
    input  logic [NREQ*DW-1:0] ReqC,
    output logic [NREQ-1:0]   Ack,
    output logic [DW-1:0]     RespData,
    output logic              RespErr,
    output logic              CoreStart,
    output logic              CoreRst,
    output logic [DW-1:0]     CoreA,
    output logic [DW-1:0]     CoreB,
    output logic [DW-1:0]     CoreC,
    input  logic              CoreDone,
    input  logic [DW-1:0]     CoreX,
    output logic              Busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [WW-1:0]   WD_LAST = WW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gnt_q, gnt_d;
    logic [WW-1:0]     wdog_q, wdog_d;
    logic [DW-1:0]     core_a_q, core_a_d;
    logic [DW-1:0]     core_b_q, core_b_d;
    logic [DW-1:0]     core_c_q, core_c_d;
    logic [DW-1:0]     resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              core_start_q, core_start_d;
    logic              core_rst_q, core_rst_d;
    logic              busy_q, busy_d;

    // Round-robin search: first set Req bit at or after ptr_q, wrapping.
    logic              arb_found;
    logic [PW-1:0]     arb_win;
    logic [PW-1:0]     arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        arb_cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            arb_cand = PW'((32'(ptr_q) + k) % NREQ);
            if (!arb_found && Req[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        wdog_d       = wdog_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_c_d     = core_c_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = 1'b0;
        ack_d        = '0;
        core_start_d = 1'b0;
        core_rst_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d        = arb_win;
                    core_a_d     = ReqA[arb_win*DW +: DW];
                    core_b_d     = ReqB[arb_win*DW +: DW];
                    core_c_d     = ReqC[arb_win*DW +: DW];
                    // Registered pulse: high for the whole LAUNCH cycle.
                    core_start_d = 1'b1;
                    state_d      = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                // CoreDone is deliberately not looked at here: it may still
                // be high from the core's previous job.
                wdog_d  = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (CoreDone) begin
                    // Done takes priority over an expiring watchdog.
                    resp_data_d = CoreX;
                    resp_err_d  = 1'b0;
                    ack_d       = ONE_HOT << gnt_q;
                    state_d     = S_RESPOND;
                end else if (wdog_q == WD_LAST) begin
                    // WAIT spans TIMEOUT cycles; this is its last edge.
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    core_rst_d  = 1'b1;
                    ack_d       = ONE_HOT << gnt_q;
                    state_d     = S_RESPOND;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end

            S_RESPOND: begin
                ptr_d   = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            gnt_q        <= '0;
            wdog_q       <= '0;
            core_a_q     <= '0;
            core_b_q     <= '0;
            core_c_q     <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            ack_q        <= '0;
            core_start_q <= 1'b0;
            core_rst_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            wdog_q       <= wdog_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_c_q     <= core_c_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            ack_q        <= ack_d;
            core_start_q <= core_start_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
        end
    end

    assign Ack       = ack_q;
    assign RespData  = resp_data_q;
    assign RespErr   = resp_err_q;
    assign CoreStart = core_start_q;
    assign CoreRst   = core_rst_q;
    assign CoreA     = core_a_q;
    assign CoreB     = core_b_q;
    assign CoreC     = core_c_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_hlsm_core_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hlsm_core_arbiter
//
// Bench for hlsm_core_arbiter with NREQ=4, DW=16, TIMEOUT=8. Requesters and a
// behavioural core (fixed latency, result A + B*C or a fixed value, Done held
// high after completion until the next job is under way) are stepped from a
// single process once per falling edge. Expected responses are queued when a
// job is posted and compared when Ack appears.
// ---------------------------------------------------------------------------
module tb_hlsm_core_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 16;
    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic [NREQ-1:0]   Req;
    logic [NREQ*DW-1:0] ReqA, ReqB, ReqC;
    logic [NREQ-1:0]   Ack;
    logic [DW-1:0]     RespData;
    logic              RespErr, CoreStart, CoreRst, Busy;
    logic [DW-1:0]     CoreA, CoreB, CoreC;
    logic              CoreDone = 1'b0;
    logic [DW-1:0]     CoreX = '0;

    always #5 Clk = ~Clk;

    hlsm_core_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .ReqA(ReqA), .ReqB(ReqB), .ReqC(ReqC),
        .Ack(Ack), .RespData(RespData), .RespErr(RespErr),
        .CoreStart(CoreStart), .CoreRst(CoreRst),
        .CoreA(CoreA), .CoreB(CoreB), .CoreC(CoreC),
        .CoreDone(CoreDone), .CoreX(CoreX), .Busy(Busy)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [NREQ-1:0] ack;
        logic [DW-1:0]   data;
        logic            err;
        logic [DW-1:0]   a, b, c;
        int              lat;
    } exp_t;
    exp_t sb[$];

    // requester state
    int            jobs_left[NREQ];
    int            svc[NREQ];
    logic [DW-1:0] op_a[NREQ], op_b[NREQ], op_c[NREQ];
    bit            wd_pending = 0;
    int            wd_idx = 0;

    always_comb begin
        Req  = '0;
        ReqA = '0;
        ReqB = '0;
        ReqC = '0;
        for (int i = 0; i < NREQ; i++) begin
            Req[i]            = (jobs_left[i] > 0);
            ReqA[i*DW +: DW]  = op_a[i];
            ReqB[i*DW +: DW]  = op_b[i];
            ReqC[i*DW +: DW]  = op_c[i];
        end
    end

    // core model state
    int            core_lat = 2;
    bit            core_fixed = 0;
    logic [DW-1:0] core_fixv = '0;
    bit            core_active = 0;
    int            core_since = 0;
    logic [DW-1:0] core_res = '0;

    // monitor state
    int cyc = 0, start_cyc = 0, mon_since = 100;
    int n_start = 0, n_ack = 0, n_crst = 0;
    int exp_starts = 0, exp_errs = 0;

    function automatic logic [DW-1:0] fa(int i, int n); return DW'(i*256 + n*17 + 5); endfunction
    function automatic logic [DW-1:0] fb(int i, int n); return DW'(-(i*3 + n + 1)); endfunction
    function automatic logic [DW-1:0] fc(int i, int n); return DW'(n*1000 - i*77 + 3); endfunction

    task automatic sb_push(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input int lat, input bit fixed,
                           input logic [DW-1:0] fv);
        exp_t e;
        logic [DW-1:0] prod;
        prod  = DW'(a + b * c);
        e.ack = NREQ'(1) << i;
        e.err = (lat > TMO);
        e.data = e.err ? '0 : (fixed ? fv : prod);
        e.a = a; e.b = b; e.c = c;
        e.lat = e.err ? TMO + 1 : lat + 1;
        sb.push_back(e);
        exp_starts++;
        if (e.err) exp_errs++;
    endtask

    task automatic start_job(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] c, input int lat, input bit fixed,
                             input logic [DW-1:0] fv);
        core_lat = lat; core_fixed = fixed; core_fixv = fv;
        op_a[i] = a; op_b[i] = b; op_c[i] = c;
        sb_push(i, a, b, c, lat, fixed, fv);
        jobs_left[i] = 1;
    endtask

    // One clock step: monitor, then core model, then requester reactions.
    task automatic tick();
        @(negedge Clk);
        cyc++;
        if (!Rst) begin
            if (CoreStart) begin
                n_start++;
                start_cyc = cyc;
                mon_since = 0;
                if (sb.size() == 0) check("start_unexpected", 1, 0);
                else begin
                    check("launch_a", CoreA, sb[0].a);
                    check("launch_b", CoreB, sb[0].b);
                    check("launch_c", CoreC, sb[0].c);
                end
            end else begin
                mon_since++;
            end
            if (mon_since == 1 && Busy && sb.size() > 0) begin
                check("wait_a", CoreA, sb[0].a);
                check("wait_b", CoreB, sb[0].b);
                check("wait_c", CoreC, sb[0].c);
            end
            if (CoreRst) n_crst++;
            if (Ack != '0) begin
                n_ack++;
                if (sb.size() == 0) check("ack_unexpected", 32'(Ack), 0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_vec", 32'(Ack), 32'(e.ack));
                    check("resp_data", 32'(RespData), 32'(e.data));
                    check("resp_err", 32'(RespErr), 32'(e.err));
                    check("core_rst_with_ack", 32'(CoreRst), 32'(e.err));
                    check("ack_latency", 32'(cyc - start_cyc), 32'(e.lat));
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (Ack[i]) begin
                        svc[i]++;
                        if (jobs_left[i] > 0) jobs_left[i]--;
                        op_a[i] = fa(i, svc[i]);
                        op_b[i] = fb(i, svc[i]);
                        op_c[i] = fc(i, svc[i]);
                    end
                end
            end
        end
        // core: Done stays high after completion until the job after next Start
        if (Rst || CoreRst) begin
            CoreDone = 1'b0;
            core_active = 0;
        end else if (CoreStart) begin
            core_active = 1;
            core_since = 0;
            core_res = core_fixed ? core_fixv : DW'(CoreA + CoreB * CoreC);
        end else if (core_active) begin
            core_since++;
            if (core_since == core_lat) begin
                CoreDone = 1'b1;
                CoreX = core_res;
                core_active = 0;
            end else begin
                CoreDone = 1'b0;
                CoreX = 16'hBEEF;
            end
        end
        if (wd_pending && CoreStart && !Rst) begin
            jobs_left[wd_idx] = 0;
            op_a[wd_idx] = 16'hDEAD;
            op_b[wd_idx] = 16'hDEAD;
            op_c[wd_idx] = 16'hDEAD;
            wd_pending = 0;
        end
    endtask

    task automatic drain(input int budget);
        bool_loop: for (int k = 0; k < budget; k++) begin
            bit idle;
            idle = (sb.size() == 0) && !Busy;
            for (int i = 0; i < NREQ; i++) if (jobs_left[i] > 0) idle = 0;
            if (idle) return;
            tick();
        end
        check("drain_timeout", 1, 0);
    endtask

    initial begin
        int s0, c0, a0;
        for (int i = 0; i < NREQ; i++) begin
            jobs_left[i] = 0; svc[i] = 0;
            op_a[i] = fa(i, 0); op_b[i] = fb(i, 0); op_c[i] = fc(i, 0);
        end

        // Reset with every requester asking.
        for (int i = 0; i < NREQ; i++) jobs_left[i] = 2;
        tick();
        check("rst_ack", 32'(Ack), 0);
        check("rst_start", 32'(CoreStart), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_respdata", 32'(RespData), 0);
        check("rst_corea", 32'(CoreA), 0);
        check("rst_corerst", 32'(CoreRst), 0);
        tick();

        // Fairness: grants 0,1,2,3,0,1,2,3.
        core_lat = 2; core_fixed = 0;
        for (int k = 0; k < 8; k++)
            sb_push(k % 4, fa(k % 4, k / 4), fb(k % 4, k / 4), fc(k % 4, k / 4), 2, 0, '0);
        Rst = 1'b0;
        drain(200);

        // Single job on requester 2.
        s0 = n_start;
        start_job(2, 16'd5, 16'hFFFD, 16'd7, 3, 1, 16'h0042);
        drain(50);
        check("single_start_count", 32'(n_start - s0), 1);

        // Timeout, then a normal job.
        c0 = n_crst;
        start_job(1, 16'h1234, 16'h0002, 16'h0003, NEVER, 0, '0);
        drain(60);
        check("timeout_corerst_count", 32'(n_crst - c0), 1);
        start_job(3, 16'h7FFF, 16'h0001, 16'h0001, 2, 0, '0);
        drain(50);

        // Done on the expiry edge (stale Done from the last job spans LAUNCH).
        start_job(0, 16'h0100, 16'hFFFF, 16'h0010, TMO, 1, 16'h8001);
        drain(60);
        // One cycle later it is a timeout.
        start_job(2, 16'h0001, 16'h0002, 16'h0003, TMO + 1, 0, '0);
        drain(60);

        // Req withdrawn and operands scrambled once the job launches.
        start_job(3, 16'h0003, 16'h0004, 16'h0005, 1, 0, '0);
        drain(50);
        wd_pending = 1; wd_idx = 1;
        start_job(1, 16'h0A0A, 16'hF00F, 16'h0055, 4, 0, '0);
        drain(50);

        // Reset in the middle of WAIT.
        s0 = n_start;
        start_job(3, 16'h0011, 16'h0022, 16'h0033, NEVER, 0, '0);
        for (int k = 0; k < 20 && n_start == s0; k++) tick();
        check("rst_mid_launch_seen", 32'(n_start - s0), 1);
        tick(); tick(); tick();
        jobs_left[3] = 0;
        a0 = n_ack; c0 = n_crst;
        Rst = 1'b1;
        tick();
        check("midrst_busy", 32'(Busy), 0);
        check("midrst_ack", 32'(Ack), 0);
        check("midrst_start", 32'(CoreStart), 0);
        Rst = 1'b0;
        sb.delete();
        exp_errs--; // the dropped job never reaches its watchdog
        for (int k = 0; k < TMO + 4; k++) tick();
        check("midrst_no_ack", 32'(n_ack - a0), 0);
        check("midrst_no_corerst", 32'(n_crst - c0), 0);

        // Normal job after the reset.
        start_job(2, 16'h0009, 16'h0008, 16'h0007, 1, 0, '0);
        drain(50);

        check("total_starts", 32'(n_start), 32'(exp_starts));
        check("total_corerst", 32'(n_crst), 32'(exp_errs));
        check("queue_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
